// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter (dmem_arbiter, arb2_select).
// Tie-break policy is selected with DMEM_ARB_RR_EN.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_id_e;

    localparam int CNT_W = 4;

    function automatic port_id_e other_port(input port_id_e p);
        return (p == PORT_C) ? PORT_D : PORT_C;
    endfunction

endpackage

// File: rtl/arb2_select.sv
// Combinational two-way winner pick between the CPU (C) and DMA (D) ports.
// DMEM_ARB_RR_EN defined: ties alternate via last_grant; undefined: C always wins ties.
module arb2_select
    import dmem_arb_pkg::*;
(
    input  logic     c_req,
    input  logic     d_req,
`ifdef DMEM_ARB_RR_EN
    input  port_id_e last_grant,
`endif
    output logic     grant_vld,
    output port_id_e grant_id
);

    always_comb begin
        grant_vld = c_req | d_req;
        grant_id  = PORT_C;
        if (c_req && d_req) begin
`ifdef DMEM_ARB_RR_EN
            grant_id = other_port(last_grant);
`else
            grant_id = PORT_C;
`endif
        end else if (d_req) begin
            grant_id = PORT_D;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between CPU (C) and DMA (D) requesters.
// Round-robin tie-break with DMEM_ARB_RR_EN, fixed C priority otherwise.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [DATA_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ready,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    port_id_e          id_q;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              grant_vld;
    port_id_e          grant_id;
    logic              in_busy, in_done, last_cycle;

`ifdef DMEM_ARB_RR_EN
    port_id_e last_grant;

    // Reset to D so the first tie after reset goes to C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= PORT_D;
        end else if (state_q == DONE) begin
            last_grant <= id_q;
        end
    end
`endif

    arb2_select u_sel (
        .c_req      (c_req),
        .d_req      (d_req),
`ifdef DMEM_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .grant_vld  (grant_vld),
        .grant_id   (grant_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = BUSY;
            BUSY:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latches, latency counter and read-data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            id_q    <= PORT_C;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        id_q    <= grant_id;
                        we_q    <= (grant_id == PORT_D) ? d_we    : c_we;
                        addr_q  <= (grant_id == PORT_D) ? d_addr  : c_addr;
                        wdata_q <= (grant_id == PORT_D) ? d_wdata : c_wdata;
                        cnt_q   <= CNT_W'(MEM_LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        rdata_q <= we_q ? '0 : mem_dout;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_busy    = (state_q == BUSY);
    assign in_done    = (state_q == DONE);
    assign last_cycle = in_busy && (cnt_q == '0);

    // Memory bus is held at zero outside BUSY so an aborted access leaves nothing driven.
    assign mem_addr  = in_busy ? addr_q  : '0;
    assign mem_din   = in_busy ? wdata_q : '0;
    assign mem_read  = in_busy && !we_q;
    assign mem_write = last_cycle && we_q;
    assign busy      = in_busy || in_done;

    assign c_ready = in_done && (id_q == PORT_C);
    assign d_ready = in_done && (id_q == PORT_D);
    assign c_rdata = c_ready ? rdata_q : '0;
    assign d_rdata = d_ready ? rdata_q : '0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port between two requesters: the CPU load/store path (port C) and a DMA/debug loader (port D). Each requester uses a req/ready handshake. The arbiter latches the winning request, drives the memory's addr/din/mem_read/mem_write for a configurable emulated access latency, then returns read data with a one-cycle ready pulse. It sits between the core's MEM stage and the data memory.

## Interface
Parameters:
- MEM_LATENCY, 1: BUSY cycles per access; legal range 1..15.
- DATA_W, 32: data and address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- c_req  in  1  CPU request
- c_we  in  1  CPU write (1) / read (0)
- c_addr  in  DATA_W  CPU byte address
- c_wdata  in  DATA_W  CPU write data
- c_ready  out  1  CPU access complete (one-cycle pulse)
- c_rdata  out  DATA_W  CPU read data, valid while c_ready=1
- d_req, d_we, d_addr, d_wdata, d_ready, d_rdata: same as the C port, for DMA
- mem_addr  out  DATA_W  to memory addr
- mem_din  out  DATA_W  to memory din
- mem_read  out  1  to memory mem_read
- mem_write  out  1  to memory mem_write
- mem_dout  in  DATA_W  from memory dout (asynchronous read)
- busy  out  1  high in BUSY and DONE

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any req is high, pick a winner and latch id, we, addr and wdata.
  - Load cnt = MEM_LATENCY-1 and go to BUSY. Otherwise stay in IDLE.
- BUSY:
  - mem_addr and mem_din come from the latches.
  - mem_read = ~we for all BUSY cycles.
  - At cnt==0:
    - write: mem_write=1 for exactly this cycle.
    - read: capture mem_dout into the rdata register.
    - Go to DONE.
  - At cnt>0: decrement cnt.
- DONE:
  - ready=1 for the winner only. {c,d}_rdata = rdata register (zero for a write).
  - Update last_grant to the winner and go to IDLE unconditionally.
- Winner selection:
  - Only one req high: that port wins.
  - Both high: the port that is not last_grant wins.
- Requester rules:
  - Hold req and all fields stable from assertion until the cycle ready is seen.
  - Deassert or re-present req in the cycle after ready.
  - Changing latched fields mid-access has no effect.
- Outputs outside BUSY: mem_addr, mem_din, mem_read and mem_write are all 0.
- The low address bits pass through unchanged; the memory ignores them.
- Reset values: state=IDLE, cnt=0, last_grant=D (so C wins the first tie), rdata=0. Every output is 0.
- Reset mid-access aborts immediately. No mem_write is issued after reset asserts, and no ready is issued for the aborted access.

## Timing
- Request sampled at edge T (state IDLE). BUSY covers cycles T+1..T+MEM_LATENCY. ready is high in cycle T+MEM_LATENCY+1.
- The write commits at the edge that ends the last BUSY cycle.
- The next arbitration is the cycle after DONE. Throughput is one access per MEM_LATENCY+2 cycles.
- ready is high for exactly one cycle per accepted request, and never on both ports at once.
- A req asserted while busy=1 waits, with no loss.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin tie-break using last_grant, as described above.
- DMEM_ARB_RR_EN undefined: fixed priority, C always wins ties. last_grant is not implemented and D can starve.

## Structure
- Package dmem_arb_pkg holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - port ids (PORT_C=1'b0, PORT_D=1'b1)
  - width of cnt (4 bits)
- Sub-module arb2_select: combinational 2-way winner pick from c_req, d_req and last_grant, with the macro-controlled policy. The FSM, latches and counter live in the top level.

## Test plan
- Reset: reset=0 with all reqs high -> every output 0, no mem_write. Release reset -> C granted first.
- Single write then read, MEM_LATENCY=1: C writes 0xDEADBEEF to 0x40 -> mem_write pulse, c_ready at T+2. C reads 0x40 -> c_rdata=0xDEADBEEF.
- Contention, RR enabled: c_req and d_req held high for 4 accesses -> grants C,D,C,D. d_rdata returns only on D's ready.
- Fixed priority, macro undefined: both reqs held high -> four C grants, d_ready never asserts.
- Latency: MEM_LATENCY=4 read -> mem_read high for 4 cycles, ready at T+5, throughput one access per 6 cycles.
- Mid-access reset: assert reset during cycle 2 of a 4-cycle write -> memory word unchanged, no ready, FSM in IDLE.
